// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory read and decode handshake bundle for fetch_unit
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC control, memory req/ack, decode valid/ready
// Optional misaligned-PC trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_offset,
  output logic              pc_set,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  fetch_unit_if.master      bus,
  output logic              fetch_fault
);

  localparam logic [ADDR_W-1:0] PC_INCR = ADDR_W'(4);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_DRAIN, ST_FAULT} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_DRAIN} state_t;
`endif

  state_t             state_q, state_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               fetch_fault_q, fetch_fault_d;
`endif

  logic               mem_req_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic               pc_set_c;
  logic [ADDR_W-1:0]  pc_offset_c;

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    req_addr_d    = req_addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_fault_d = fetch_fault_q;
`endif
    mem_req_c     = 1'b0;
    mem_addr_c    = req_addr_q;
    pc_set_c      = 1'b0;
    pc_offset_c   = '0;

    case (state_q)
      ST_FETCH: begin
        mem_addr_c = pc;
        req_addr_d = pc;
`ifdef FETCH_ALIGN_CHECK_EN
        // A redirect arriving with a bad PC repairs it before any request goes out.
        if (pc[1:0] != 2'b00) begin
          if (!redirect) begin
            state_d       = ST_FAULT;
            fetch_fault_d = 1'b1;
          end
        end else
`endif
        begin
          mem_req_c = 1'b1;
          if (redirect) begin
            // An un-acked read cannot be withdrawn, so wait it out in DRAIN.
            if (!bus.mem_ack) begin
              state_d = ST_DRAIN;
            end
          end else if (bus.mem_ack) begin
            instr_d       = bus.mem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_offset_c   = PC_INCR;
            state_d       = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect || bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          state_d = ST_FETCH;
        end
      end

`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        if (redirect) begin
          fetch_fault_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
`endif

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (redirect) begin
      pc_set_c    = 1'b1;
      pc_offset_c = redirect_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      req_addr_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      req_addr_q    <= req_addr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault_q <= fetch_fault_d;
`endif
    end
  end

  // Reset forces the PC to hold and suppresses any request.
  assign bus.mem_req     = mem_req_c & ~rst;
  assign bus.mem_addr    = mem_addr_c;
  assign pc_set          = pc_set_c & ~rst;
  assign pc_offset       = rst ? '0 : pc_offset_c;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault     = fetch_fault_q;
`else
  assign fetch_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with PC and memory models
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_offset;
  logic        pc_set;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .INSTR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_offset       (pc_offset),
    .pc_set          (pc_set),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bus             (bus.master),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Program counter model: set loads the offset, otherwise counter += offset.
  task automatic step();
    logic [31:0] nxt;
    nxt = pc_set ? pc_offset : pc + pc_offset;
    @(posedge clk); #1;
    pc = nxt;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b1; redirect = 1'b0; redirect_target = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    pc = start;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0; redirect = 1'b1; redirect_target = 32'h40;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF0000; bus.instr_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%h exp=0", bus.mem_req); end
    n_checks++; if (pc_set !== 1'b0) begin n_fail++; $display("FAIL rst_pc_set got=%h exp=0", pc_set); end
    n_checks++; if (pc_offset !== 32'h0) begin n_fail++; $display("FAIL rst_pc_offset got=%h exp=0", pc_offset); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid got=%h exp=0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got=%h exp=0", bus.instr_pc); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_fault got=%h exp=0", fetch_fault); end
    do_reset(32'h0);
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_req got=%h/%h exp=1/0", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset(32'h0);
    bus.instr_ready = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== 32'h0 || pc_offset !== 32'h4 || pc_set !== 1'b0) begin n_fail++; $display("FAIL b2b_ack1 addr=%h off=%h set=%h exp=0/4/0", bus.mem_addr, pc_offset, pc_set); end
    step(); bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h11111111 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL b2b_instr1 v=%h instr=%h pc=%h exp=1/11111111/0", bus.instr_valid, bus.instr, bus.instr_pc); end
    n_checks++; if (bus.mem_req !== 1'b0 || pc_offset !== 32'h0) begin n_fail++; $display("FAIL b2b_hold1 req=%h off=%h exp=0/0", bus.mem_req, pc_offset); end
    step(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h22222222;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4 || pc_offset !== 32'h4 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack2 req=%h addr=%h off=%h v=%h exp=1/4/4/0", bus.mem_req, bus.mem_addr, pc_offset, bus.instr_valid); end
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h22222222 || bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL b2b_instr2 v=%h instr=%h pc=%h exp=1/22222222/4", bus.instr_valid, bus.instr, bus.instr_pc); end
    step();
    @(negedge clk);
    n_checks++; if (pc !== 32'h8 || bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL b2b_pc pc=%h addr=%h exp=8/8", pc, bus.mem_addr); end
  endtask

  task automatic test_hold_stall();
    do_reset(32'h40);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE0040; bus.instr_ready = 1'b0;
    @(negedge clk);
    step(); bus.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hCAFE0040 || bus.instr_pc !== 32'h40) begin n_fail++; $display("FAIL stall_hold[%0d] v=%h instr=%h pc=%h exp=1/cafe0040/40", i, bus.instr_valid, bus.instr, bus.instr_pc); end
      n_checks++; if (bus.mem_req !== 1'b0 || pc_offset !== 32'h0 || pc_set !== 1'b0) begin n_fail++; $display("FAIL stall_quiet[%0d] req=%h off=%h set=%h exp=0/0/0", i, bus.mem_req, pc_offset, pc_set); end
      step();
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44) begin n_fail++; $display("FAIL stall_release v=%h req=%h addr=%h exp=0/1/44", bus.instr_valid, bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_delayed_ack();
    do_reset(32'h80);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = (i == 3); bus.mem_rdata = (i == 3) ? 32'hBEEF0080 : 32'h0BAD0BAD;
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL dly_req[%0d] req=%h addr=%h v=%h exp=1/80/0", i, bus.mem_req, bus.mem_addr, bus.instr_valid); end
      n_checks++; if (pc_offset !== ((i == 3) ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL dly_off[%0d] got=%h exp=%h", i, pc_offset, (i == 3) ? 32'h4 : 32'h0); end
      step();
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hBEEF0080 || bus.instr_pc !== 32'h80) begin n_fail++; $display("FAIL dly_instr v=%h instr=%h pc=%h exp=1/beef0080/80", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  task automatic test_redirect_drain();
    do_reset(32'h20);
    bus.instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h100;
    @(negedge clk);
    n_checks++; if (pc_set !== 1'b1 || pc_offset !== 32'h100 || bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL drn_redir set=%h off=%h addr=%h exp=1/100/20", pc_set, pc_offset, bus.mem_addr); end
    step(); redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20 || pc_set !== 1'b0 || pc_offset !== 32'h0) begin n_fail++; $display("FAIL drn_wait req=%h addr=%h set=%h off=%h exp=1/20/0/0", bus.mem_req, bus.mem_addr, pc_set, pc_offset); end
    step(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD0020;
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== 32'h20 || pc_offset !== 32'h0) begin n_fail++; $display("FAIL drn_ack addr=%h off=%h exp=20/0", bus.mem_addr, pc_offset); end
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL drn_next v=%h req=%h addr=%h exp=0/1/100", bus.instr_valid, bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h01000100;
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_pc !== 32'h100 || bus.instr !== 32'h01000100) begin n_fail++; $display("FAIL drn_fetch pc=%h instr=%h exp=100/01000100", bus.instr_pc, bus.instr); end
  endtask

  task automatic test_redirect_hold();
    do_reset(32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h33333333; bus.instr_ready = 1'b0;
    @(negedge clk);
    step(); bus.mem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h300;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || pc_set !== 1'b1 || pc_offset !== 32'h300) begin n_fail++; $display("FAIL hred_cycle v=%h set=%h off=%h exp=1/1/300", bus.instr_valid, pc_set, pc_offset); end
    step(); redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL hred_next v=%h req=%h addr=%h exp=0/1/300", bus.instr_valid, bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h10);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    step(); rst = 1'b1; redirect = 1'b1; redirect_target = 32'h990;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0 || pc_set !== 1'b0 || pc_offset !== 32'h0) begin n_fail++; $display("FAIL rmid_quiet req=%h set=%h off=%h exp=0/0/0", bus.mem_req, pc_set, pc_offset); end
    step(); rst = 1'b0; redirect = 1'b0; pc = 32'h50; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hABCD0001;
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== 32'h50 || pc_offset !== 32'h4) begin n_fail++; $display("FAIL rmid_ack addr=%h off=%h exp=50/4", bus.mem_addr, pc_offset); end
    step(); bus.mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h50 || bus.instr !== 32'hABCD0001) begin n_fail++; $display("FAIL rmid_instr v=%h pc=%h instr=%h exp=1/50/abcd0001", bus.instr_valid, bus.instr_pc, bus.instr); end
    do_reset(32'h60);
    redirect = 1'b1; redirect_target = 32'h70;
    @(negedge clk);
    step(); redirect = 1'b0; rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h70) begin n_fail++; $display("FAIL rmid_drain req=%h addr=%h exp=1/70", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_align();
    do_reset(32'h102);
    bus.instr_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL algn_noreq got=%h exp=0", bus.mem_req); end
    step();
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1 || bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL algn_fault f=%h req=%h v=%h exp=1/0/0", fetch_fault, bus.mem_req, bus.instr_valid); end
    redirect = 1'b1; redirect_target = 32'h200;
    #1;
    n_checks++; if (pc_set !== 1'b1 || pc_offset !== 32'h200) begin n_fail++; $display("FAIL algn_redir set=%h off=%h exp=1/200", pc_set, pc_offset); end
    step(); redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL algn_clear f=%h req=%h addr=%h exp=0/1/200", fetch_fault, bus.mem_req, bus.mem_addr); end
`else
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h102 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL algn_ignored req=%h addr=%h f=%h exp=1/102/0", bus.mem_req, bus.mem_addr, fetch_fault); end
    step();
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b0 || bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL algn_nofault f=%h req=%h exp=0/1", fetch_fault, bus.mem_req); end
`endif
  endtask

  // Program-order scoreboard: delivered words must follow +4 / redirect order.
  task automatic test_random();
    logic [31:0] exp_pc, cap_addr;
    logic [31:0] prev_off;
    logic        outstanding, prev_valid, prev_redir, rose;
    int          wait_left, transfers;
    do_reset(32'h0);
    exp_pc = 32'h0; outstanding = 1'b0; wait_left = 0; transfers = 0;
    prev_valid = 1'b0; prev_redir = 1'b1; prev_off = 32'h0; cap_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redirect = ($urandom_range(0, 15) == 0);
      redirect_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      bus.instr_ready = ($urandom_range(0, 2) != 0);
      #1;
      bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (!outstanding) begin
          outstanding = 1'b1; wait_left = $urandom_range(0, 3); cap_addr = bus.mem_addr;
        end else begin
          n_checks++; if (bus.mem_addr !== cap_addr) begin n_fail++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, cap_addr); end
        end
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = word_at(bus.mem_addr); outstanding = 1'b0;
        end else begin
          wait_left--;
        end
      end
      @(negedge clk);
      n_checks++; if (pc_set !== redirect) begin n_fail++; $display("FAIL rnd_pc_set cyc=%0d got=%h exp=%h", cyc, pc_set, redirect); end
      if (redirect) begin
        n_checks++; if (pc_offset !== redirect_target) begin n_fail++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, pc_offset, redirect_target); end
      end else begin
        n_checks++; if (pc_offset !== 32'h0 && pc_offset !== 32'h4) begin n_fail++; $display("FAIL rnd_offset cyc=%0d got=%h exp=0 or 4", cyc, pc_offset); end
      end
      if (!prev_redir) begin
        rose = bus.instr_valid && !prev_valid;
        n_checks++; if (rose !== (prev_off == 32'h4)) begin n_fail++; $display("FAIL rnd_advance cyc=%0d valid_rose=%h prev_off=%h", cyc, rose, prev_off); end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        transfers++;
        n_checks++; if (bus.instr_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_order cyc=%0d got=%h exp=%h", cyc, bus.instr_pc, exp_pc); end
        n_checks++; if (bus.instr !== word_at(bus.instr_pc)) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, bus.instr, word_at(bus.instr_pc)); end
        exp_pc = exp_pc + 32'h4;
      end
      if (redirect) exp_pc = redirect_target;
      prev_valid = bus.instr_valid; prev_redir = redirect; prev_off = pc_offset;
      step();
    end
    n_checks++; if (transfers < 200) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=200", transfers); end
    redirect = 1'b0; bus.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_stall();
    test_delayed_ack();
    test_redirect_drain();
    test_redirect_hold();
    test_reset_mid();
    test_align();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that drives the program counter's control inputs and consumes its `counter` value. Each cycle it decides whether the PC advances by 4, jumps to an absolute target, or holds. It issues a read to instruction memory over a req/ack handshake and presents the returned word to decode over a valid/ready handshake. It sits between the program counter, instruction memory and the decode stage.

## Interface
- `ADDR_W`, 32, PC/address width
- `INSTR_W`, 32, instruction word width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  ADDR_W  current PC (program counter `counter`)
- `pc_offset`  out  ADDR_W  to program counter `offset`; increment, or absolute target when `pc_set`=1
- `pc_set`  out  1  to program counter `set_counter`
- `redirect`  in  1  branch/jump taken this cycle
- `redirect_target`  in  ADDR_W  absolute jump target
- `mem_req`  out  1  instruction memory read request
- `mem_addr`  out  ADDR_W  read address, stable while `mem_req`=1
- `mem_ack`  in  1  read complete, `mem_rdata` valid this cycle
- `mem_rdata`  in  INSTR_W  read data
- `instr_valid`  out  1  `instr` holds a fetched word
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  address `instr` was fetched from
- `instr_ready`  in  1  decode accepts `instr`
- `fetch_fault`  out  1  misaligned PC detected (only with `FETCH_ALIGN_CHECK_EN`)

## Operation
- States: FETCH, HOLD, DRAIN, FAULT (FAULT only with the macro). Reset state: FETCH.
- FETCH
  - `mem_req`=1; `mem_addr`=`pc` (combinational).
  - `req_addr` <= `pc` every cycle.
  - `mem_ack`=1, `redirect`=0: `instr` <= `mem_rdata`, `instr_pc` <= `pc`, `instr_valid` <= 1, `pc_offset`=4, go to HOLD.
  - `redirect`=1 with `mem_ack`=1: drop the data, stay in FETCH.
  - `redirect`=1 with `mem_ack`=0: the request cannot be withdrawn; go to DRAIN.
- HOLD
  - `mem_req`=0; `instr_valid`=1, with `instr`/`instr_pc` stable.
  - `instr_ready`=1: `instr_valid` <= 0, go to FETCH.
  - `redirect`=1: `instr_valid` <= 0, go to FETCH, regardless of `instr_ready`.
- DRAIN
  - `mem_req`=1; `mem_addr`=`req_addr` (the old address).
  - On `mem_ack`, discard `mem_rdata` and go to FETCH.
  - `redirect` in DRAIN updates the PC only; the state stays DRAIN.
- Redirect priority (any state)
  - `redirect`=1: `pc_set`=1, `pc_offset`=`redirect_target`.
  - Redirect overrides the +4 advance.
- Otherwise `pc_set`=0, `pc_offset`=0, so the PC holds.
- Arithmetic: increment is the constant 4 at ADDR_W width; PC wrap-around at 2^ADDR_W is the program counter's concern.
- Handshakes
  - Memory: `mem_addr` is stable from request assertion until `mem_ack`.
  - Decode: transfer when `instr_valid`&`instr_ready`.

## Timing
- Reset values: state FETCH, `instr_valid`=0, `instr`=0, `instr_pc`=0, `req_addr`=0, `fetch_fault`=0.
- While `rst`=1: `mem_req`=0, `pc_set`=0, `pc_offset`=0.
- `pc_offset`, `pc_set`, `mem_req` and `mem_addr` are combinational from state and inputs; the PC updates at the same clock edge as the ack/redirect.
- Zero-wait memory (ack in the request cycle): fetch-to-valid latency is 1 cycle; steady throughput is 1 instruction per 2 cycles (FETCH, HOLD).
- Reset mid-transaction: state returns to FETCH immediately; an in-flight memory ack after reset release is treated as a response to the new request.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined
  - In FETCH with `pc[1:0]`!=0: `mem_req`=0, go to FAULT.
  - FAULT: `fetch_fault`=1, `mem_req`=0, `instr_valid`=0.
  - `redirect` leaves FAULT for FETCH and clears `fetch_fault`.
  - In the same cycle, `pc_set`=1 and `pc_offset`=`redirect_target`.
- `FETCH_ALIGN_CHECK_EN` undefined
  - No FAULT state; `fetch_fault` is tied to 0.
  - `pc[1:0]` is ignored and the fetch proceeds.

## Test plan
- Reset, PC=0, memory acks same cycle with 0x11111111, then 0x22222222; `instr_ready` held 1 → `instr`=0x11111111 (`instr_pc` 0), then 0x22222222 (`instr_pc` 4); `pc_offset`=4 on each ack cycle.
- `instr_ready`=0 for 5 cycles in HOLD → `instr_valid` stays 1, `instr` stable, `mem_req`=0, `pc_offset`=0.
- Memory ack delayed 3 cycles → `mem_addr` is constant for all 4 request cycles and `instr_valid` rises after the ack edge.
- `redirect`=1 to 0x100 while waiting for ack (ack 2 cycles later) → `pc_set`=1, `pc_offset`=0x100; DRAIN holds the old `mem_addr`; data is discarded; next request addr is 0x100.
- `redirect` in HOLD with `instr_ready`=0 → `instr_valid` drops next cycle, and the next fetch uses the target.
- With `FETCH_ALIGN_CHECK_EN`, PC=0x102 → no `mem_req`, `fetch_fault`=1; `redirect` to 0x200 → fault clears and the fetch at 0x200 proceeds.
